// File: rtl/accum_pkg.sv
// Shared definitions for the frame accumulator: FSM state encoding and counter width.
package accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Sized for the largest legal frame length of 255 samples.
  localparam int CNT_W = 8;

endpackage

// File: rtl/param_full_adder.sv
// WIDTH-bit ripple-style adder with carry in and carry out.
module param_full_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + (WIDTH + 1)'(cin);

endmodule

// File: rtl/param_accumulator.sv
// Sums COUNT unsigned samples per frame and presents the result with an overflow flag.
// Build macro PARAM_ACCUMULATOR_SATURATE_EN: defined = clamp to all-ones on overflow, undefined = wrap.
//
// Handshake: a sample transfers on a rising edge with in_valid && in_ready; a result
// transfers on a rising edge with out_valid && out_ready. out_sum/out_ovf are stable
// while out_valid is high, and in_ready is low whenever a result is pending.
module param_accumulator
  import accum_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int COUNT = 4,
  parameter int ACC_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  state_t             state, state_nxt;
  logic [ACC_W-1:0]   acc, acc_nxt;
  logic [ACC_W-1:0]   add_b, add_sum;
  logic               add_cout;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               ovf, ovf_nxt;
  logic               accept;
  logic               last;

  assign add_b = ACC_W'(in_data);

  param_full_adder #(.WIDTH(ACC_W)) u_add (
    .a    (acc),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // in_ready is gated by rst so it reads 0 during reset without waiting for an edge.
  assign in_ready  = !rst && (state != HOLD);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt + CNT_W'(1)) == CNT_W'(COUNT);
  assign out_valid = (state == HOLD);
  assign out_sum   = acc;
  assign out_ovf   = ovf;

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    if (flush) begin
      state_nxt = IDLE;
      acc_nxt   = '0;
      cnt_nxt   = '0;
      ovf_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc_nxt   = add_b;
            cnt_nxt   = CNT_W'(1);
            ovf_nxt   = 1'b0;
            state_nxt = (COUNT == 1) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            cnt_nxt = cnt + CNT_W'(1);
`ifdef PARAM_ACCUMULATOR_SATURATE_EN
            // Once clamped the frame stays at all-ones regardless of later samples.
            if (ovf || add_cout) begin
              acc_nxt = '1;
              ovf_nxt = 1'b1;
            end else begin
              acc_nxt = add_sum;
            end
`else
            acc_nxt = add_sum;
            if (add_cout) ovf_nxt = 1'b1;
`endif
            if (last) state_nxt = HOLD;
          end
        end
        HOLD: begin
          if (out_ready) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
    end
  end

endmodule

// File: doc/param_accumulator.md
PARAM_ACCUMULATOR -- requirements
Module: param_accumulator

Interface
REQ-001 Parameter WIDTH, default 4, sets the input sample width in bits.
REQ-002 Parameter COUNT, default 4, sets the number of samples summed per frame; legal range is 1..255.
REQ-003 Parameter ACC_W, default 6, sets the accumulator and result width in bits; the legal minimum is WIDTH.
REQ-004 The block uses one clock; reset is asynchronous and active-high.
REQ-005 Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- flush  input  1  synchronous frame abort.
- in_valid  input  1  sample offered.
- in_data  input  WIDTH  unsigned sample.
- in_ready  output  1  sample accepted when high with in_valid.
- out_valid  output  1  frame result available.
- out_ready  input  1  consumer takes result.
- out_sum  output  ACC_W  frame sum.
- out_ovf  output  1  frame overflow flag.

Function
REQ-006 The FSM SHALL have three states: IDLE, ACCUM and HOLD.
REQ-007 A sample is accepted on a rising edge where in_valid and in_ready are both 1; in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD.
REQ-008 IDLE, on accept: acc <= zero-extended in_data, cnt <= 1, ovf <= 0; next state is ACCUM, or HOLD if COUNT==1.
REQ-009 ACCUM, on accept: acc <= acc + zero-extended in_data, cnt <= cnt+1; on the accept that makes cnt equal COUNT, the next state SHALL be HOLD.
REQ-010 With no accept, acc, cnt and the state SHALL hold.
REQ-011 out_valid SHALL be 1 exactly while in HOLD, rising in the cycle after the COUNT-th accept (latency 1 clock from the last sample).
REQ-012 out_sum and out_ovf SHALL be stable while out_valid is 1.
REQ-013 HOLD, with out_ready=1 on an edge: the result is consumed and the next state is IDLE; out_ready is ignored outside HOLD.
REQ-014 In HOLD with out_ready=0, the block SHALL hold indefinitely (backpressure) with in_ready=0.
REQ-015 A carry out of bit ACC_W-1 on any accumulate SHALL set ovf; ovf is sticky for the frame and clears only at the next frame start or on flush/reset.
REQ-016 flush=1 on an edge, in any state, SHALL force IDLE with acc=0, cnt=0 and ovf=0.
- flush has priority over a simultaneous sample accept or result consume.
- A result pending in HOLD is discarded.
REQ-017 Samples are not accepted in the cycle of the HOLD->IDLE transition, because in_ready=0 in HOLD; the first sample of the next frame is accepted one cycle later at the earliest.

Reset
REQ-018 While rst=1, the block SHALL be in IDLE with acc=0, cnt=0, ovf=0, out_valid=0, in_ready=0, out_sum=0 and out_ovf=0.
REQ-019 After rst deasserts, in_ready SHALL be 1 from the first clock edge onward.
REQ-020 Reset asserted mid-frame or in HOLD SHALL discard all partial and pending state immediately, without waiting for a clock edge.

Configuration
REQ-021 The macro PARAM_ACCUMULATOR_SATURATE_EN selects between saturating and wrapping overflow behaviour.
- Defined: on overflow, acc SHALL clamp to all-ones and stay there for the rest of the frame; out_ovf=1.
- Not defined: acc SHALL wrap modulo 2^ACC_W; out_ovf=1.

Structure
REQ-022 A shared package accum_pkg SHALL hold the FSM state encoding (IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2) and the counter-width constant.
REQ-023 The counter width SHALL be an 8-bit constant, sized for the COUNT maximum of 255.
REQ-024 The addition SHALL use one sub-module instance of param_full_adder with WIDTH=ACC_W and cin=0; its cout is the overflow source.

Verification
REQ-025 Normal frame, WIDTH=4, COUNT=4, ACC_W=6: samples 1,2,3,4 on consecutive cycles -> out_valid=1 the next cycle, out_sum=10, out_ovf=0.
REQ-026 Wrap, ACC_W=5, macro off: samples 15,15,15,15 -> out_sum=28, out_ovf=1.
REQ-027 Saturate, ACC_W=5, macro on: samples 15,15,15,15 -> out_sum=31, out_ovf=1.
REQ-028 Backpressure: hold out_ready=0 for 3 cycles in HOLD -> out_sum stays 10, in_ready=0 and in_valid is ignored; out_ready=1 -> IDLE and out_valid=0 the next cycle.
REQ-029 Flush and reset mid-frame: after 2 samples, assert flush together with in_valid -> sample dropped, cnt=0; a fresh frame of 5,5,5,5 then gives out_sum=20.
REQ-030 Asynchronous reset: assert rst between clock edges while in ACCUM -> all outputs are 0 at once.
